// File: rtl/snake_body_sched_pkg.sv
// Shared definitions for the greedy-snake body scheduler.
// Holds the playfield/buffer geometry, the forward and mode codes shared with
// the key controller, the scheduler FSM encoding and the {x,y} segment payload.
package snake_body_sched_pkg;

    localparam int unsigned GRID_W   = 32;
    localparam int unsigned GRID_H   = 24;
    localparam int unsigned COORD_W  = 5;
    localparam int unsigned MAX_LEN  = 64;
    localparam int unsigned PTR_W    = 6;
    localparam int unsigned LEN_W    = PTR_W + 1;
    localparam int unsigned INIT_LEN = 3;
    localparam int unsigned INIT_X   = 8;
    localparam int unsigned INIT_Y   = 12;

    typedef enum logic [1:0] {
        FORWARD_XP = 2'b00,
        FORWARD_XM = 2'b01,
        FORWARD_YM = 2'b10,
        FORWARD_YP = 2'b11
    } forward_e;

    typedef enum logic [3:0] {
        MODE_RESET  = 4'd0,
        MODE_UPDATE = 4'd1
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CALC,
        ST_SCAN,
        ST_WRITE,
        ST_FIN
    } state_e;

    // One body segment as stored in the BSRAM word: {x, y}.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } seg_t;

    function automatic seg_t pack_seg(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
        seg_t s;
        s.x = x;
        s.y = y;
        return s;
    endfunction

endpackage

// File: rtl/snake_body_sched_if.sv
// Single-port BSRAM bus between the body scheduler (master) and the body store
// (slave). Read data returns one cycle after the address is presented.
//  mem_we     write enable
//  mem_addr   word address
//  mem_wdata  segment to write
//  mem_rdata  segment at the previous cycle's address
interface snake_body_sched_if;
    import snake_body_sched_pkg::*;

    logic             mem_we;
    logic [PTR_W-1:0] mem_addr;
    seg_t             mem_wdata;
    seg_t             mem_rdata;

    modport master (output mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/snake_body_sched_head_step.sv
// Combinational next-head calculation for one step in the forward direction.
//  head_x/head_y  current head
//  forward        direction code (forward_e)
//  nxt_x_c/_y_c   head after the step (unchanged on a wall hit)
//  wall_hit_c     the step would leave the playfield
module snake_body_sched_head_step
    import snake_body_sched_pkg::*;
(
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic [1:0]         forward,
    output logic [COORD_W-1:0] nxt_x_c,
    output logic [COORD_W-1:0] nxt_y_c,
    output logic               wall_hit_c
);

    always_comb begin
        nxt_x_c    = head_x;
        nxt_y_c    = head_y;
        wall_hit_c = 1'b0;
        case (forward_e'(forward))
            FORWARD_XP: begin
                if (head_x == COORD_W'(GRID_W - 1)) wall_hit_c = 1'b1;
                else                                nxt_x_c    = head_x + COORD_W'(1);
            end
            FORWARD_XM: begin
                if (head_x == '0) wall_hit_c = 1'b1;
                else              nxt_x_c    = head_x - COORD_W'(1);
            end
            FORWARD_YM: begin
                if (head_y == '0) wall_hit_c = 1'b1;
                else              nxt_y_c    = head_y - COORD_W'(1);
            end
            FORWARD_YP: begin
                if (head_y == COORD_W'(GRID_H - 1)) wall_hit_c = 1'b1;
                else                                nxt_y_c    = head_y + COORD_W'(1);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/snake_body_sched.sv
// Greedy-snake body scheduler: sequences init and move/grow updates of a
// circular buffer of {x,y} segments in a single-port BSRAM and lends the BSRAM
// to the display read port whenever the update engine is idle.
// Optional feature: define SNAKE_SELF_COLLIDE_EN to add a SCAN state that reads
// the body and flags a head-on-body collision before the head is written.
//  clk, rst        clock, asynchronous active-low reset
//  en/mode/forward/grow  command strobe, 0=reset snake 1=update, direction, keep tail
//  busy/done/dead  engine owns BSRAM / end-of-command pulse / sticky collision
//  head_x/head_y/length  current head and segment count
//  rd_req/rd_idx   display read of segment rd_idx (0 = tail)
//  rd_gnt          combinational grant; rd_valid/rd_x/rd_y one cycle later
//  mem_bus         BSRAM master port
module snake_body_sched
    import snake_body_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [3:0]         mode,
    input  logic [1:0]         forward,
    input  logic               grow,
    output logic               busy,
    output logic               done,
    output logic               dead,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [LEN_W-1:0]   length,
    input  logic               rd_req,
    input  logic [PTR_W-1:0]   rd_idx,
    output logic               rd_gnt,
    output logic               rd_valid,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    snake_body_sched_if.master mem_bus
);

    state_e             state_q, state_d;
    logic               busy_d, done_d, dead_d, rd_valid_d;
    logic [COORD_W-1:0] head_x_d, head_y_d;
    logic [LEN_W-1:0]   length_d;
    logic [PTR_W-1:0]   head_ptr, head_ptr_d;
    logic [1:0]         fwd_q, fwd_d;
    logic               grow_q, grow_d;
    logic [COORD_W-1:0] nxt_x_q, nxt_x_d, nxt_y_q, nxt_y_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic [COORD_W-1:0] step_x_c, step_y_c;
    logic               wall_c;
    logic               grow_eff_c;
    logic [PTR_W-1:0]   tail_ptr_c;
    logic               we_c;
    logic [PTR_W-1:0]   eng_addr_c;
    seg_t               wdata_c;

    snake_body_sched_head_step u_head_step (
        .head_x     (head_x),
        .head_y     (head_y),
        .forward    (fwd_q),
        .nxt_x_c    (step_x_c),
        .nxt_y_c    (step_y_c),
        .wall_hit_c (wall_c)
    );

    // Tail is implicit; a full buffer (length[PTR_W-1:0]==0) puts it just past the head.
    assign tail_ptr_c = head_ptr - length[PTR_W-1:0] + PTR_W'(1);
    // Growing at full length is ignored, so the tail is overwritten as on a plain move.
    assign grow_eff_c = grow_q & (length != LEN_W'(MAX_LEN));

    // Display only sees the BSRAM while idle and not in a command cycle.
    assign rd_gnt             = rd_req & (state_q == ST_IDLE) & ~en;
    assign mem_bus.mem_we     = we_c;
    assign mem_bus.mem_addr   = rd_gnt ? (tail_ptr_c + rd_idx) : eng_addr_c;
    assign mem_bus.mem_wdata  = wdata_c;
    assign rd_x               = mem_bus.mem_rdata.x;
    assign rd_y               = mem_bus.mem_rdata.y;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dead     <= 1'b0;
            rd_valid <= 1'b0;
            head_x   <= '0;
            head_y   <= '0;
            length   <= '0;
            head_ptr <= '0;
            fwd_q    <= '0;
            grow_q   <= 1'b0;
            nxt_x_q  <= '0;
            nxt_y_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy     <= busy_d;
            done     <= done_d;
            dead     <= dead_d;
            rd_valid <= rd_valid_d;
            head_x   <= head_x_d;
            head_y   <= head_y_d;
            length   <= length_d;
            head_ptr <= head_ptr_d;
            fwd_q    <= fwd_d;
            grow_q   <= grow_d;
            nxt_x_q  <= nxt_x_d;
            nxt_y_q  <= nxt_y_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, datapath updates and BSRAM engine port.
    always_comb begin
        state_d    = state_q;
        dead_d     = dead;
        head_x_d   = head_x;
        head_y_d   = head_y;
        length_d   = length;
        head_ptr_d = head_ptr;
        fwd_d      = fwd_q;
        grow_d     = grow_q;
        nxt_x_d    = nxt_x_q;
        nxt_y_d    = nxt_y_q;
        cnt_d      = cnt_q;
        we_c       = 1'b0;
        eng_addr_c = '0;
        wdata_c    = '0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (mode == MODE_RESET) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end else if (mode == MODE_UPDATE && !dead && length != '0) begin
                        state_d = ST_CALC;
                        fwd_d   = forward;
                        grow_d  = grow;
                    end
                end
            end
            ST_INIT: begin
                we_c       = 1'b1;
                eng_addr_c = cnt_q[PTR_W-1:0];
                wdata_c    = pack_seg(COORD_W'(INIT_X - INIT_LEN + 1) + cnt_q[COORD_W-1:0],
                                      COORD_W'(INIT_Y));
                if (cnt_q == LEN_W'(INIT_LEN - 1)) begin
                    state_d    = ST_FIN;
                    head_ptr_d = PTR_W'(INIT_LEN - 1);
                    length_d   = LEN_W'(INIT_LEN);
                    dead_d     = 1'b0;
                    head_x_d   = COORD_W'(INIT_X);
                    head_y_d   = COORD_W'(INIT_Y);
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            ST_CALC: begin
                if (wall_c) begin
                    dead_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    nxt_x_d = step_x_c;
                    nxt_y_d = step_y_c;
                    cnt_d   = '0;
`ifdef SNAKE_SELF_COLLIDE_EN
                    state_d = ST_SCAN;
`else
                    state_d = ST_WRITE;
`endif
                end
            end
`ifdef SNAKE_SELF_COLLIDE_EN
            // cnt issues body index cnt and compares the data of index cnt-1;
            // index 0 (tail) only counts when it is being kept.
            ST_SCAN: begin
                if (cnt_q < length) eng_addr_c = tail_ptr_c + cnt_q[PTR_W-1:0];
                if (cnt_q != '0 && (cnt_q != LEN_W'(1) || grow_eff_c) &&
                    mem_bus.mem_rdata == pack_seg(nxt_x_q, nxt_y_q)) begin
                    dead_d  = 1'b1;
                    state_d = ST_FIN;
                end else if (cnt_q == length) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
`endif
            ST_WRITE: begin
                we_c       = 1'b1;
                eng_addr_c = head_ptr + PTR_W'(1);
                wdata_c    = pack_seg(nxt_x_q, nxt_y_q);
                head_ptr_d = head_ptr + PTR_W'(1);
                head_x_d   = nxt_x_q;
                head_y_d   = nxt_y_q;
                if (grow_eff_c) length_d = length + LEN_W'(1);
                state_d    = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_FIN);
        rd_valid_d = rd_gnt;
    end

endmodule

// File: tb/tb_snake_body_sched.sv
// Directed self-checking bench for snake_body_sched with a behavioural BSRAM.
// Covers init, moves, wall death, grow saturation with pointer wrap, display
// arbitration and, with SNAKE_SELF_COLLIDE_EN, body collision detection.
module tb_snake_body_sched;
    import snake_body_sched_pkg::*;

`ifdef SNAKE_SELF_COLLIDE_EN
    localparam int SCAN_ON = 1;
`else
    localparam int SCAN_ON = 0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic [3:0]         mode = '0;
    logic [1:0]         forward = '0;
    logic               grow = 1'b0;
    logic               rd_req = 1'b0;
    logic [PTR_W-1:0]   rd_idx = '0;
    logic               busy, done, dead, rd_gnt, rd_valid;
    logic [COORD_W-1:0] head_x, head_y, rd_x, rd_y;
    logic [LEN_W-1:0]   length;

    int n_checks = 0;
    int n_errors = 0;

    seg_t mem [MAX_LEN];

    snake_body_sched_if bus ();

    snake_body_sched dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .forward  (forward),
        .grow     (grow),
        .busy     (busy),
        .done     (done),
        .dead     (dead),
        .head_x   (head_x),
        .head_y   (head_y),
        .length   (length),
        .rd_req   (rd_req),
        .rd_idx   (rd_idx),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .mem_bus  (bus)
    );

    always #5 clk = ~clk;

    // Single-port BSRAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int xy(input int x, input int y);
        return x * 32 + y;
    endfunction

    function automatic int scan_cycles(input int len);
        return (len + 1) * SCAN_ON;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and run to its done pulse; returns latency and write count.
    task automatic do_cmd(input logic [3:0] m, input logic [1:0] f, input logic g,
                          output int lat, output int wr);
        mode = m; forward = f; grow = g; en = 1'b1;
        cyc();
        en = 1'b0;
        lat = 1;
        wr = 0;
        while (!done && lat < 300) begin
            wr += int'(bus.mem_we);
            cyc();
            lat++;
        end
        check("cmd_done_seen", int'(done), 1);
        cyc();
    endtask

    task automatic read_seg(input int idx, output int x, output int y);
        rd_req = 1'b1;
        rd_idx = PTR_W'(idx);
        #1;
        check("rd_gnt", int'(rd_gnt), 1);
        cyc();
        rd_req = 1'b0;
        check("rd_valid", int'(rd_valid), 1);
        x = int'(rd_x);
        y = int'(rd_y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wr, x, y, k, g, v;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dead", int'(dead), 0);
        check("rst_len", int'(length), 0);
        check("rst_hx", int'(head_x), 0);
        check("rst_hy", int'(head_y), 0);
        check("rst_rdv", int'(rd_valid), 0);
        check("rst_we", int'(bus.mem_we), 0);
        rst = 1'b1;
        cyc();

        // Update with length 0 is dropped
        mode = 4'd1; en = 1'b1;
        cyc();
        en = 1'b0;
        check("len0_drop_busy", int'(busy), 0);

        // Init: one write per cycle, done after the last
        mode = 4'd0; en = 1'b1;
        cyc();
        en = 1'b0;
        for (int i = 0; i < int'(INIT_LEN); i++) begin
            check("init_busy", int'(busy), 1);
            check("init_we", int'(bus.mem_we), 1);
            check("init_addr", int'(bus.mem_addr), i);
            check("init_data", int'(bus.mem_wdata), xy(6 + i, 12));
            cyc();
        end
        check("init_done", int'(done), 1);
        check("init_len", int'(length), 3);
        check("init_hx", int'(head_x), 8);
        check("init_hy", int'(head_y), 12);
        cyc();
        check("init_idle_busy", int'(busy), 0);
        check("init_done_pulse", int'(done), 0);

        // Ignored mode
        mode = 4'd2; en = 1'b1;
        cyc();
        en = 1'b0;
        check("mode2_busy", int'(busy), 0);
        check("mode2_done", int'(done), 0);

        // Single move x+1 with exact timing
        mode = 4'd1; forward = 2'b00; grow = 1'b0; en = 1'b1;
        cyc();
        en = 1'b0;
        check("mv_calc_busy", int'(busy), 1);
        check("mv_calc_we", int'(bus.mem_we), 0);
        repeat (scan_cycles(3)) cyc();
        cyc();
        check("mv_we", int'(bus.mem_we), 1);
        check("mv_addr", int'(bus.mem_addr), 3);
        check("mv_data", int'(bus.mem_wdata), xy(9, 12));
        cyc();
        check("mv_done", int'(done), 1);
        check("mv_hx", int'(head_x), 9);
        check("mv_hy", int'(head_y), 12);
        check("mv_len", int'(length), 3);
        cyc();
        read_seg(0, x, y);
        check("mv_tail", xy(x, y), xy(7, 12));

        // Walk to (31,5) then hit the right wall
        for (int i = 0; i < 7; i++)  do_cmd(4'd1, 2'b10, 1'b0, lat, wr);
        for (int i = 0; i < 22; i++) do_cmd(4'd1, 2'b00, 1'b0, lat, wr);
        check("walk_head", xy(int'(head_x), int'(head_y)), xy(31, 5));
        check("walk_lat", lat, 3 + scan_cycles(3));
        check("walk_wr", wr, 1);
        mode = 4'd1; forward = 2'b00; en = 1'b1;
        cyc();
        en = 1'b0;
        check("wall_calc_we", int'(bus.mem_we), 0);
        cyc();
        check("wall_done", int'(done), 1);
        check("wall_dead", int'(dead), 1);
        check("wall_we", int'(bus.mem_we), 0);
        check("wall_head", xy(int'(head_x), int'(head_y)), xy(31, 5));
        cyc();

        // Update while dead is dropped
        mode = 4'd1; forward = 2'b01; en = 1'b1;
        cyc();
        en = 1'b0;
        check("dead_drop_busy", int'(busy), 0);
        k = 0;
        repeat (5) begin
            k += int'(done);
            cyc();
        end
        check("dead_drop_done", k, 0);

        // Reset-snake clears dead
        do_cmd(4'd0, 2'b00, 1'b0, lat, wr);
        check("reinit_lat", lat, 4);
        check("reinit_wr", wr, 3);
        check("reinit_dead", int'(dead), 0);
        check("reinit_len", int'(length), 3);
        check("reinit_head", xy(int'(head_x), int'(head_y)), xy(8, 12));

        // Grow 62 times: saturate at 64, head pointer wraps
        for (int i = 0; i < 62; i++) begin
            if (i < 23)      do_cmd(4'd1, 2'b00, 1'b1, lat, wr);
            else if (i < 34) do_cmd(4'd1, 2'b11, 1'b1, lat, wr);
            else             do_cmd(4'd1, 2'b01, 1'b1, lat, wr);
            if (i == 60) check("grow_len61", int'(length), 64);
        end
        check("grow_len_sat", int'(length), 64);
        check("grow_dead", int'(dead), 0);
        check("grow_head", xy(int'(head_x), int'(head_y)), xy(3, 23));
        read_seg(0, x, y);
        check("wrap_idx0", xy(x, y), xy(7, 12));
        read_seg(1, x, y);
        check("wrap_idx1", xy(x, y), xy(8, 12));
        read_seg(35, x, y);
        check("wrap_idx35", xy(x, y), xy(31, 23));
        read_seg(63, x, y);
        check("wrap_idx63", xy(x, y), xy(3, 23));
        cyc();

        // Display request held across a command: en wins, no grants while busy
        rd_req = 1'b1; rd_idx = '0;
        mode = 4'd1; forward = 2'b01; grow = 1'b0; en = 1'b1;
        #1;
        check("arb_en_wins", int'(rd_gnt), 0);
        cyc();
        en = 1'b0;
        g = 0; v = 0; k = 0;
        while (!done && k < 300) begin
            g += int'(rd_gnt);
            v += int'(rd_valid);
            cyc();
            k++;
        end
        check("arb_done_seen", int'(done), 1);
        g += int'(rd_gnt);
        v += int'(rd_valid);
        check("arb_gnt_busy", g, 0);
        check("arb_valid_busy", v, 0);
        cyc();
        check("arb_gnt_idle", int'(rd_gnt), 1);
        cyc();
        rd_req = 1'b0;
        check("arb_valid", int'(rd_valid), 1);
        check("arb_data", xy(int'(rd_x), int'(rd_y)), xy(8, 12));
        cyc();
        check("arb_valid_drop", int'(rd_valid), 0);
        check("arb_len", int'(length), 64);
        check("arb_head", xy(int'(head_x), int'(head_y)), xy(2, 23));

        // U turn into the body at length 5
        do_cmd(4'd0, 2'b00, 1'b0, lat, wr);
        do_cmd(4'd1, 2'b00, 1'b1, lat, wr);
        do_cmd(4'd1, 2'b00, 1'b1, lat, wr);
        check("u_len", int'(length), 5);
        do_cmd(4'd1, 2'b10, 1'b0, lat, wr);
        check("u_lat", lat, 3 + scan_cycles(5));
        do_cmd(4'd1, 2'b01, 1'b0, lat, wr);
        do_cmd(4'd1, 2'b11, 1'b0, lat, wr);
`ifdef SNAKE_SELF_COLLIDE_EN
        check("u_dead", int'(dead), 1);
        check("u_wr", wr, 0);
        check("u_head", xy(int'(head_x), int'(head_y)), xy(9, 11));
`else
        check("u_dead", int'(dead), 0);
        check("u_wr", wr, 1);
        check("u_head", xy(int'(head_x), int'(head_y)), xy(9, 12));
`endif

        // Stepping into the vacating tail cell is legal
        do_cmd(4'd0, 2'b00, 1'b0, lat, wr);
        do_cmd(4'd1, 2'b10, 1'b1, lat, wr);
        do_cmd(4'd1, 2'b01, 1'b0, lat, wr);
        do_cmd(4'd1, 2'b11, 1'b0, lat, wr);
        check("tail_dead", int'(dead), 0);
        check("tail_wr", wr, 1);
        check("tail_head", xy(int'(head_x), int'(head_y)), xy(7, 12));
        check("tail_len", int'(length), 4);

        // Asynchronous reset mid-command aborts it
        mode = 4'd0; en = 1'b1;
        cyc();
        en = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_len", int'(length), 0);
        check("arst_hx", int'(head_x), 0);
        check("arst_we", int'(bus.mem_we), 0);
        cyc();
        rst = 1'b1;
        k = 0;
        repeat (5) begin
            cyc();
            k += int'(done);
        end
        check("arst_no_done", k, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
